// File: rtl/idli_pkg.sv
// Shared IDLI types and constants: SQI nibble type, fetch FSM states,
// SQI burst framing sizes and the word-PC to byte-address mapping.
package idli_pkg;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic [2:0] {
        FCH_GAP    = 3'd0,
        FCH_CMD    = 3'd1,
        FCH_ADDR   = 3'd2,
        FCH_DUMMY  = 3'd3,
        FCH_STREAM = 3'd4
    } fch_state_t;

    localparam int SQI_ADDR_NIBBLES = 6;
    localparam int SQI_CMD_NIBBLES  = 2;

    // Instructions are 16b words, so the byte address is the word PC doubled.
    function automatic logic [23:0] fch_byte_addr(input logic [15:0] pc);
        return {7'b000_0000, pc, 1'b0};
    endfunction

endpackage

// File: rtl/idli_fetch_addr_shift_m.sv
// Address shifter for the SQI read burst: loads the 24b byte address and
// presents it MSB nibble first, advancing one nibble per shift.
module idli_fetch_addr_shift_m
    import idli_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift,
    input  logic [23:0] addr,
    output sqi_data_t   nibble
);

    logic [23:0] sr_r;

    // Load while idle, shift during ADDR, hold across stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_r <= 24'h00_0000;
        end else if (load) begin
            sr_r <= addr;
        end else if (shift) begin
            sr_r <= {sr_r[19:0], 4'h0};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign nibble = sr_r[23:20];

endmodule

// File: rtl/idli_fetch_ctrl_m.sv
// SQI instruction fetch sequencer: issues read bursts and streams data nibbles
// to the decoder. IDLI_FETCH_WRAP_RESTART_EN re-issues the burst on PC wrap.
module idli_fetch_ctrl_m
    import idli_pkg::*;
#(
    parameter logic [7:0]  READ_CMD      = 8'h03,
    parameter int          DUMMY_NIBBLES = 2,
    parameter int          CS_GAP        = 1,
    parameter logic [15:0] RESET_PC      = 16'h0000
) (
    input  logic        i_fch_gck,
    input  logic        i_fch_rst,
    input  logic        i_fch_stall,
    input  logic        i_fch_redirect,
    input  logic [15:0] i_fch_redirect_pc,
    input  sqi_data_t   i_fch_sqi_sio,
    output sqi_data_t   o_fch_sqi_sio,
    output logic        o_fch_sqi_sio_oe,
    output logic        o_fch_sqi_cs_n,
    output logic        o_fch_sqi_sck_en,
    output sqi_data_t   o_fch_enc,
    output logic        o_fch_enc_vld,
    output logic [15:0] o_fch_pc
);

    localparam logic [2:0] GAP_LAST   = 3'(CS_GAP - 1);
    localparam logic [2:0] CMD_LAST   = 3'(SQI_CMD_NIBBLES - 1);
    localparam logic [2:0] ADDR_LAST  = 3'(SQI_ADDR_NIBBLES - 1);
    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_NIBBLES - 1);

    fch_state_t  state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [15:0] pc_r, pc_s;
    logic [1:0]  nib_idx_r, nib_idx_s;
    logic        cs_n_s, oe_s, sck_en_s, enc_vld_s;
    sqi_data_t   sio_s, addr_nibble_s;

    idli_fetch_addr_shift_m u_addr_shift (
        .clk    (i_fch_gck),
        .rst    (i_fch_rst),
        .load   (state_r != FCH_ADDR),
        .shift  ((state_r == FCH_ADDR) && !i_fch_stall),
        .addr   (fch_byte_addr(pc_r)),
        .nibble (addr_nibble_s)
    );

    // FSM state, shared counter, nibble index and PC registers.
    always_ff @(posedge i_fch_gck or posedge i_fch_rst) begin
        if (i_fch_rst) begin
            state_r   <= FCH_GAP;
            cnt_r     <= 3'd0;
            pc_r      <= RESET_PC;
            nib_idx_r <= 2'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            pc_r      <= pc_s;
            nib_idx_r <= nib_idx_s;
        end
    end

    // Next-state and SQI/decoder output decode; redirect overrides everything.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pc_s      = pc_r;
        nib_idx_s = nib_idx_r;
        cs_n_s    = 1'b0;
        oe_s      = 1'b0;
        sio_s     = 4'h0;
        sck_en_s  = !i_fch_stall;
        enc_vld_s = 1'b0;
        case (state_r)
            FCH_GAP: begin
                cs_n_s   = 1'b1;
                sck_en_s = 1'b0;
                if (cnt_r == GAP_LAST) begin
                    state_s = FCH_CMD;
                    cnt_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            FCH_CMD: begin
                oe_s  = 1'b1;
                sio_s = (cnt_r == 3'd0) ? READ_CMD[7:4] : READ_CMD[3:0];
                if (i_fch_stall) begin
                    cnt_s = cnt_r;
                end else if (cnt_r == CMD_LAST) begin
                    state_s = FCH_ADDR;
                    cnt_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            FCH_ADDR: begin
                oe_s  = 1'b1;
                sio_s = addr_nibble_s;
                if (i_fch_stall) begin
                    cnt_s = cnt_r;
                end else if (cnt_r == ADDR_LAST) begin
                    state_s = (DUMMY_NIBBLES == 0) ? FCH_STREAM : FCH_DUMMY;
                    cnt_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            FCH_DUMMY: begin
                if (i_fch_stall) begin
                    cnt_s = cnt_r;
                end else if (cnt_r == DUMMY_LAST) begin
                    state_s = FCH_STREAM;
                    cnt_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            FCH_STREAM: begin
                enc_vld_s = !i_fch_stall;
                if (i_fch_stall) begin
                    nib_idx_s = nib_idx_r;
                end else begin
                    nib_idx_s = nib_idx_r + 2'd1;
                    if (nib_idx_r == 2'd3) begin
                        pc_s = pc_r + 16'd1;
`ifdef IDLI_FETCH_WRAP_RESTART_EN
                        // Memory may not wrap at byte 0x1FFFF: restart the burst at 0.
                        if (pc_r == 16'hFFFF) begin
                            state_s = FCH_GAP;
                            cnt_s   = 3'd0;
                        end else begin
                            state_s = FCH_STREAM;
                        end
`endif
                    end else begin
                        pc_s = pc_r;
                    end
                end
            end
            default: begin
                state_s  = FCH_GAP;
                cnt_s    = 3'd0;
                cs_n_s   = 1'b1;
                sck_en_s = 1'b0;
            end
        endcase
        if (i_fch_redirect) begin
            state_s   = FCH_GAP;
            cnt_s     = 3'd0;
            pc_s      = i_fch_redirect_pc;
            nib_idx_s = 2'd0;
            enc_vld_s = 1'b0;
        end else begin
            enc_vld_s = enc_vld_s;
        end
    end

    // Data passes straight from the pin; enc_vld qualifies it.
    assign o_fch_enc        = i_fch_sqi_sio;
    assign o_fch_enc_vld    = enc_vld_s;
    assign o_fch_sqi_sio    = sio_s;
    assign o_fch_sqi_sio_oe = oe_s;
    assign o_fch_sqi_cs_n   = cs_n_s;
    assign o_fch_sqi_sck_en = sck_en_s;
    assign o_fch_pc         = pc_r;

endmodule

// File: tb/tb_idli_fetch_ctrl_m.sv
// Directed self-checking bench for idli_fetch_ctrl_m (default parameters).
module tb_idli_fetch_ctrl_m;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [3:0]  sio_in;
    logic [3:0]  sio_out;
    logic        sio_oe;
    logic        cs_n;
    logic        sck_en;
    logic [3:0]  enc;
    logic        enc_vld;
    logic [15:0] pc;

    int          n_chk;
    int          n_fail;
    logic [15:0] exp_pc;
    logic [1:0]  exp_idx;

    idli_fetch_ctrl_m dut (
        .i_fch_gck         (clk),
        .i_fch_rst         (rst),
        .i_fch_stall       (stall),
        .i_fch_redirect    (redirect),
        .i_fch_redirect_pc (redirect_pc),
        .i_fch_sqi_sio     (sio_in),
        .o_fch_sqi_sio     (sio_out),
        .o_fch_sqi_sio_oe  (sio_oe),
        .o_fch_sqi_cs_n    (cs_n),
        .o_fch_sqi_sck_en  (sck_en),
        .o_fch_enc         (enc),
        .o_fch_enc_vld     (enc_vld),
        .o_fch_pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic st, input logic rd, input logic [15:0] rpc, input logic [3:0] sio);
        @(negedge clk);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        sio_in      = sio;
        #1;
    endtask

    task automatic exp_ctl(input string tag, input logic e_cs, input logic e_oe,
                           input logic e_sck, input logic e_vld);
        chk({tag, "_cs_n"}, 32'(cs_n), 32'(e_cs));
        chk({tag, "_oe"}, 32'(sio_oe), 32'(e_oe));
        chk({tag, "_sck_en"}, 32'(sck_en), 32'(e_sck));
        chk({tag, "_enc_vld"}, 32'(enc_vld), 32'(e_vld));
    endtask

    task automatic gap_cycle(input logic [15:0] e_pc);
        tick(1'b0, 1'b0, 16'h0000, 4'h0);
        exp_ctl("gap", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("gap_pc", 32'(pc), 32'(e_pc));
    endtask

    // CMD, ADDR (optionally stalled 3 cycles before nibble stall_at) and DUMMY.
    task automatic cmd_addr(input logic [23:0] a, input int stall_at);
        tick(1'b0, 1'b0, 16'h0000, 4'h0);
        exp_ctl("cmd0", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("cmd0_sio", 32'(sio_out), 32'h0);
        tick(1'b0, 1'b0, 16'h0000, 4'h0);
        exp_ctl("cmd1", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("cmd1_sio", 32'(sio_out), 32'h3);
        for (int i = 0; i < 6; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    tick(1'b1, 1'b0, 16'h0000, 4'h0);
                    exp_ctl("addr_stall", 1'b0, 1'b1, 1'b0, 1'b0);
                    chk("addr_stall_sio", 32'(sio_out), 32'(a[23-4*i -: 4]));
                end
            end
            tick(1'b0, 1'b0, 16'h0000, 4'h0);
            exp_ctl("addr", 1'b0, 1'b1, 1'b1, 1'b0);
            chk("addr_sio", 32'(sio_out), 32'(a[23-4*i -: 4]));
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 16'h0000, 4'h0);
            exp_ctl("dummy", 1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic stream(input int n);
        logic [3:0] v;
        for (int i = 0; i < n; i++) begin
            v = 4'((i * 3 + 1) & 15);
            tick(1'b0, 1'b0, 16'h0000, v);
            exp_ctl("strm", 1'b0, 1'b0, 1'b1, 1'b1);
            chk("strm_enc", 32'(enc), 32'(v));
            chk("strm_pc", 32'(pc), 32'(exp_pc));
            if (exp_idx == 2'd3) begin
                exp_pc = exp_pc + 16'd1;
            end
            exp_idx = exp_idx + 2'd1;
        end
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        sio_in      = 4'h0;
        exp_pc      = 16'h0000;
        exp_idx     = 2'd0;

        #2;
        exp_ctl("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_sio", 32'(sio_out), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);

        // Reset release, first burst from pc 0.
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_ctl("gap0", 1'b1, 1'b0, 1'b0, 1'b0);
        cmd_addr(24'h00_0000, 6);
        stream(8);

        // Redirect with stall during STREAM.
        tick(1'b1, 1'b1, 16'h1234, 4'h9);
        chk("redir_vld", 32'(enc_vld), 32'h0);
        chk("redir_sck", 32'(sck_en), 32'h0);
        exp_pc  = 16'h1234;
        exp_idx = 2'd0;
        gap_cycle(16'h1234);
        cmd_addr(24'h00_2468, 3);
        stream(5);

        // Redirect in STREAM, then in GAP, then on the first CMD cycle.
        tick(1'b0, 1'b1, 16'h0100, 4'h5);
        chk("r1_vld", 32'(enc_vld), 32'h0);
        tick(1'b0, 1'b1, 16'h0200, 4'h0);
        exp_ctl("r2_gap", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r2_pc", 32'(pc), 32'h0100);
        gap_cycle(16'h0200);
        tick(1'b0, 1'b1, 16'h0300, 4'h0);
        exp_ctl("r3_cmd", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("r3_pc", 32'(pc), 32'h0200);
        exp_pc  = 16'h0300;
        exp_idx = 2'd0;
        gap_cycle(16'h0300);
        cmd_addr(24'h00_0600, 6);
        stream(4);

        // PC wrap at 16'hFFFF.
        tick(1'b0, 1'b1, 16'hFFFF, 4'h0);
        chk("w_vld", 32'(enc_vld), 32'h0);
        exp_pc  = 16'hFFFF;
        exp_idx = 2'd0;
        gap_cycle(16'hFFFF);
        cmd_addr(24'h01_FFFE, 6);
        stream(4);
`ifdef IDLI_FETCH_WRAP_RESTART_EN
        gap_cycle(16'h0000);
        cmd_addr(24'h00_0000, 6);
        stream(2);
`else
        tick(1'b0, 1'b0, 16'h0000, 4'h7);
        exp_ctl("wrap", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("wrap_enc", 32'(enc), 32'h7);
        chk("wrap_pc", 32'(pc), 32'h0);
`endif

        // Asynchronous reset in the middle of a stream.
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_ctl("arst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("arst_pc", 32'(pc), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
